// File: rtl/pc_pkg.sv
// Shared types for the fetch-stage PC sequencer: default widths, PC type and
// the next-PC select encoding, listed in ascending priority.
package pc_pkg;

  localparam int unsigned PC_W_DEF  = 8;
  localparam int unsigned OFF_W_DEF = 8;

  typedef logic [PC_W_DEF-1:0] pc_t;

  typedef enum logic [2:0] {
    SEQ,
    HOLD,
    BR,
    CALL,
    RET
  } npc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. Pushing when full overwrites the oldest
// entry; popping when empty leaves state untouched and flags underflow.
module pc_ras #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     push_data,
  output logic [W-1:0]     top,
  output logic [CNT_W-1:0] cnt,
  output logic             empty,
  output logic             ovf,
  output logic             unf
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q, unf_q;
  logic             full;

  // ptr_q addresses the next free slot, so the top sits one below it.
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign top   = mem_q[ptr_q - PTR_W'(1)];
  assign cnt   = cnt_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      if (pop) begin
        if (empty) begin
          unf_q <= 1'b1;
        end else begin
          ptr_q <= ptr_q - PTR_W'(1);
          cnt_q <= cnt_q - CNT_W'(1);
        end
      end else if (push) begin
        ptr_q <= ptr_q + PTR_W'(1);
        if (full) begin
          ovf_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Entry contents need no reset; only pointer and count define validity.
  always_ff @(posedge clk) begin
    if (push && !pop) begin
      mem_q[ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: sequential advance, stall hold, and branch/call/return
// redirects resolved in ID/EX, with a registered flush pulse per redirect.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned     PC_W      = PC_W_DEF,
  parameter int unsigned     OFF_W     = OFF_W_DEF,
  parameter int unsigned     RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int unsigned     PC_INC    = 1,
  localparam int unsigned    CNT_W     = $clog2(RAS_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              br_taken_idex,
  input  logic              call_idex,
  input  logic              ret_idex,
  input  logic [PC_W-1:0]   pc_idex,
  input  logic [OFF_W-1:0]  rel_add_idex,
  output logic [PC_W-1:0]   pc_if,
  output logic              flush,
  output logic              ras_ovf,
  output logic              ras_unf,
  output logic [CNT_W-1:0]  ras_cnt
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            flush_q, flush_d;
  logic [PC_W-1:0] rel_sext, rel_target, ret_addr, ras_top;
  logic            ras_empty;
  npc_sel_e        sel;

  assign rel_sext   = PC_W'($signed(rel_add_idex));
  assign rel_target = pc_idex + rel_sext;
  assign ret_addr   = pc_idex + PC_W'(PC_INC);

  always_comb begin
    sel = SEQ;
    if (ret_idex)           sel = RET;
    else if (call_idex)     sel = CALL;
    else if (br_taken_idex) sel = BR;
    else if (stall)         sel = HOLD;
  end

  always_comb begin
    pc_d    = pc_q + PC_W'(PC_INC);
    flush_d = 1'b0;
    unique case (sel)
      RET: begin
        pc_d    = ras_empty ? ret_addr : ras_top;
        flush_d = 1'b1;
      end
      CALL, BR: begin
        pc_d    = rel_target;
        flush_d = 1'b1;
      end
      HOLD:    pc_d = pc_q;
      default: pc_d = pc_q + PC_W'(PC_INC);
    endcase
  end

  pc_ras #(
    .DEPTH(RAS_DEPTH),
    .W    (PC_W)
  ) u_ras (
    .clk      (clk),
    .rst      (rst),
    .push     (sel == CALL),
    .pop      (sel == RET),
    .push_data(ret_addr),
    .top      (ras_top),
    .cnt      (ras_cnt),
    .empty    (ras_empty),
    .ovf      (ras_ovf),
    .unf      (ras_unf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      flush_q <= flush_d;
    end
  end

  assign pc_if = pc_q;
  assign flush = flush_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: the driver queues hand-computed expected
// outputs per clock edge, and a monitor pops and compares them on the falling edge.
module tb_pc_sequencer;

  typedef struct packed {
    logic [7:0] pc;
    logic       fl;
    logic       ov;
    logic       un;
    logic [2:0] cnt;
  } exp_t;

  logic       clk, rst, stall, br, call, ret;
  logic [7:0] pc_idex, rel;
  logic [7:0] pc_if;
  logic       flush, ras_ovf, ras_unf;
  logic [2:0] ras_cnt;

  exp_t  exp_q [$];
  string name_q [$];
  int    total, passed;
  logic  done;

  pc_sequencer #(
    .PC_W     (8),
    .OFF_W    (8),
    .RAS_DEPTH(4),
    .RESET_PC (8'h10),
    .PC_INC   (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .br_taken_idex(br),
    .call_idex    (call),
    .ret_idex     (ret),
    .pc_idex      (pc_idex),
    .rel_add_idex (rel),
    .pc_if        (pc_if),
    .flush        (flush),
    .ras_ovf      (ras_ovf),
    .ras_unf      (ras_unf),
    .ras_cnt      (ras_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t mk(input logic [7:0] p, input logic f, input logic o,
                              input logic u, input logic [2:0] c);
    exp_t e;
    e.pc  = p;
    e.fl  = f;
    e.ov  = o;
    e.un  = u;
    e.cnt = c;
    return e;
  endfunction

  task automatic expect_now(input string nm, input exp_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Apply inputs, let one rising edge sample them, then queue the expected outputs.
  task automatic cyc(input string nm, input logic s, input logic b, input logic c,
                     input logic r, input logic [7:0] px, input logic [7:0] rl,
                     input exp_t e);
    stall   = s;
    br      = b;
    call    = c;
    ret     = r;
    pc_idex = px;
    rel     = rl;
    @(posedge clk);
    #1;
    expect_now(nm, e);
  endtask

  always @(negedge clk) begin
    exp_t  e;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      total++;
      if (pc_if === e.pc && flush === e.fl && ras_ovf === e.ov && ras_unf === e.un &&
          ras_cnt === e.cnt) begin
        passed++;
      end else begin
        $display("FAIL %s: got pc_if=%h flush=%b ovf=%b unf=%b cnt=%0d, want pc_if=%h flush=%b ovf=%b unf=%b cnt=%0d",
                 nm, pc_if, flush, ras_ovf, ras_unf, ras_cnt, e.pc, e.fl, e.ov, e.un, e.cnt);
      end
    end
    if (done && exp_q.size() == 0) begin
      $display("%0d/%0d checks passed", passed, total);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    total = 0;
    passed = 0;
    done  = 1'b0;
    rst   = 1'b1;
    stall = 1'b0;
    br    = 1'b0;
    call  = 1'b0;
    ret   = 1'b0;
    pc_idex = 8'h00;
    rel     = 8'h00;

    @(posedge clk);
    #1;
    expect_now("reset", mk(8'h10, 0, 0, 0, 3'd0));
    rst = 1'b0;

    // Sequential fetch from RESET_PC.
    cyc("seq1", 0, 0, 0, 0, 8'h00, 8'h00, mk(8'h11, 0, 0, 0, 3'd0));
    cyc("seq2", 0, 0, 0, 0, 8'h00, 8'h00, mk(8'h12, 0, 0, 0, 3'd0));
    cyc("seq3", 0, 0, 0, 0, 8'h00, 8'h00, mk(8'h13, 0, 0, 0, 3'd0));
    cyc("seq4", 0, 0, 0, 0, 8'h00, 8'h00, mk(8'h14, 0, 0, 0, 3'd0));

    // Stall hold, then branch overriding stall with a negative offset.
    cyc("br_to_20", 0, 1, 0, 0, 8'h20, 8'h00, mk(8'h20, 1, 0, 0, 3'd0));
    cyc("stall1", 1, 0, 0, 0, 8'h00, 8'h00, mk(8'h20, 0, 0, 0, 3'd0));
    cyc("stall2", 1, 0, 0, 0, 8'h00, 8'h00, mk(8'h20, 0, 0, 0, 3'd0));
    cyc("stall_br", 1, 1, 0, 0, 8'h1E, 8'hFC, mk(8'h1A, 1, 0, 0, 3'd0));
    cyc("after_br", 0, 0, 0, 0, 8'h00, 8'h00, mk(8'h1B, 0, 0, 0, 3'd0));

    // Wrap-around of target adder and sequential increment.
    cyc("br_wrap", 0, 1, 0, 0, 8'hFE, 8'h05, mk(8'h03, 1, 0, 0, 3'd0));
    cyc("br_to_ff", 0, 1, 0, 0, 8'hFD, 8'h02, mk(8'hFF, 1, 0, 0, 3'd0));
    cyc("seq_wrap", 0, 0, 0, 0, 8'h00, 8'h00, mk(8'h00, 0, 0, 0, 3'd0));

    // Call then return.
    cyc("call", 0, 0, 1, 0, 8'h30, 8'h10, mk(8'h40, 1, 0, 0, 3'd1));
    cyc("call_seq", 0, 0, 0, 0, 8'h00, 8'h00, mk(8'h41, 0, 0, 0, 3'd1));
    cyc("ret", 0, 0, 0, 1, 8'h99, 8'h00, mk(8'h31, 1, 0, 0, 3'd0));
    cyc("ret_seq", 0, 0, 0, 0, 8'h00, 8'h00, mk(8'h32, 0, 0, 0, 3'd0));

    // Five calls overflow a 4-deep stack; four returns drain it; one more underflows.
    cyc("ovf_c1", 0, 0, 1, 0, 8'h00, 8'h10, mk(8'h10, 1, 0, 0, 3'd1));
    cyc("ovf_c2", 0, 0, 1, 0, 8'h10, 8'h10, mk(8'h20, 1, 0, 0, 3'd2));
    cyc("ovf_c3", 0, 0, 1, 0, 8'h20, 8'h10, mk(8'h30, 1, 0, 0, 3'd3));
    cyc("ovf_c4", 0, 0, 1, 0, 8'h30, 8'h10, mk(8'h40, 1, 0, 0, 3'd4));
    cyc("ovf_c5", 0, 0, 1, 0, 8'h40, 8'h10, mk(8'h50, 1, 1, 0, 3'd4));
    cyc("pop1", 0, 0, 0, 1, 8'h77, 8'h00, mk(8'h41, 1, 0, 0, 3'd3));
    cyc("pop2", 0, 0, 0, 1, 8'h77, 8'h00, mk(8'h31, 1, 0, 0, 3'd2));
    cyc("pop3", 0, 0, 0, 1, 8'h77, 8'h00, mk(8'h21, 1, 0, 0, 3'd1));
    cyc("pop4", 0, 0, 0, 1, 8'h77, 8'h00, mk(8'h11, 1, 0, 0, 3'd0));
    cyc("unf", 0, 0, 0, 1, 8'h50, 8'h00, mk(8'h51, 1, 0, 1, 3'd0));
    cyc("unf_seq", 0, 0, 0, 0, 8'h00, 8'h00, mk(8'h52, 0, 0, 0, 3'd0));

    // Call+return together pops only; a following return then underflows.
    cyc("pre_call", 0, 0, 1, 0, 8'h60, 8'h08, mk(8'h68, 1, 0, 0, 3'd1));
    cyc("call_ret", 0, 0, 1, 1, 8'h70, 8'h04, mk(8'h61, 1, 0, 0, 3'd0));
    cyc("no_push", 0, 0, 0, 1, 8'h80, 8'h00, mk(8'h81, 1, 0, 1, 3'd0));

    // Branch+call is one redirect with a push.
    cyc("br_call", 0, 1, 1, 0, 8'h90, 8'h10, mk(8'hA0, 1, 0, 0, 3'd1));
    cyc("br_call_ret", 0, 0, 0, 1, 8'h00, 8'h00, mk(8'h91, 1, 0, 0, 3'd0));

    // Asynchronous reset between edges.
    cyc("pre_rst", 0, 0, 1, 0, 8'h00, 8'h40, mk(8'h40, 1, 0, 0, 3'd1));
    stall = 1'b0;
    br    = 1'b0;
    call  = 1'b0;
    ret   = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (pc_if === 8'h10 && flush === 1'b0 && ras_cnt === 3'd0) begin
      passed++;
    end else begin
      $display("FAIL async_rst_immediate: got pc_if=%h flush=%b cnt=%0d, want pc_if=10 flush=0 cnt=0",
               pc_if, flush, ras_cnt);
    end
    expect_now("async_rst", mk(8'h10, 0, 0, 0, 3'd0));
    @(posedge clk);
    #1;
    expect_now("rst_held", mk(8'h10, 0, 0, 0, 3'd0));
    rst = 1'b0;
    cyc("post_rst", 0, 0, 0, 0, 8'h00, 8'h00, mk(8'h11, 0, 0, 0, 3'd0));
    total++;
    if (pc_if === 8'h11 && ras_cnt === 3'd0 && ras_ovf === 1'b0 && ras_unf === 1'b0) begin
      passed++;
    end else begin
      $display("FAIL post_rst_direct: got pc_if=%h cnt=%0d ovf=%b unf=%b, want pc_if=11 cnt=0 ovf=0 unf=0",
               pc_if, ras_cnt, ras_ovf, ras_unf);
    end

    done = 1'b1;
  end

endmodule
